// File: rtl/dnn_accel_system_cpu_ocimem_pkg.sv
// Shared types and JTAG payload field positions for the OCI RAM arbiter.
package dnn_accel_system_cpu_ocimem_pkg;

    typedef enum logic [1:0] {OP_LOAD, OP_LOAD_RD, OP_WRITE, OP_READ} jtag_op_t;
    typedef enum logic {IDLE, RD_WAIT} state_t;

    localparam int JDO_W       = 38;
    localparam int JDO_ADDR_HI = 25;
    localparam int JDO_ADDR_LO = 18;
    localparam int JDO_RDEN    = 17;
    localparam int JDO_WD_HI   = 34;
    localparam int JDO_WD_LO   = 3;

endpackage

// File: rtl/dnn_accel_system_cpu_ocimem_jtag_cmd.sv
// Decodes JTAG ocimem pulses into a single pending-op slot and owns the
// auto-incrementing JTAG address and the sticky overrun flag.
module dnn_accel_system_cpu_ocimem_jtag_cmd
    import dnn_accel_system_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              jp_clear,
    input  logic              addr_inc,
    output logic              capture,
    output logic              jp_valid,
    output jtag_op_t          jp_op,
    output logic [ADDR_W-1:0] jp_addr,
    output logic [DATA_W-1:0] jp_data,
    output logic [ADDR_W-1:0] jtag_addr,
    output logic              jtag_overrun
);

    jtag_op_t          cap_op;
    logic [ADDR_W-1:0] cap_addr;
    logic [ADDR_W-1:0] jdo_addr;
    logic              jdo_unused;

    assign capture    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jdo_addr   = ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
    assign jdo_unused = ^{jdo[JDO_W-1:JDO_WD_HI+1], jdo[JDO_WD_LO-1:0]};

    // Priority when pulses coincide: write, then address load, then plain read.
    always_comb begin
        cap_op   = OP_READ;
        cap_addr = jtag_addr;
        if (take_action_ocimem_b) begin
            cap_op = OP_WRITE;
        end else if (take_action_ocimem_a) begin
            cap_op   = jdo[JDO_RDEN] ? OP_LOAD_RD : OP_LOAD;
            cap_addr = jdo_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jp_valid     <= 1'b0;
            jtag_addr    <= '0;
            jtag_overrun <= 1'b0;
        end else begin
            if (capture) begin
                jp_valid <= 1'b1;
                if (jp_valid) jtag_overrun <= 1'b1;
            end else if (jp_clear) begin
                jp_valid <= 1'b0;
            end
            if (take_action_ocimem_a && !take_action_ocimem_b)
                jtag_addr <= jdo_addr;
            else if (addr_inc)
                jtag_addr <= jtag_addr + ADDR_W'(1);
        end
    end

    // Payload only; qualified by jp_valid, so no reset needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            jp_op   <= cap_op;
            jp_addr <= cap_addr;
            jp_data <= DATA_W'(jdo[JDO_WD_HI:JDO_WD_LO]);
        end
    end

endmodule

// File: rtl/dnn_accel_system_cpu_ocimem_arbiter.sv
// Single-port OCI RAM arbiter between the JTAG debug path and the Avalon
// debug_slave, alternating grants so neither side starves.
module dnn_accel_system_cpu_ocimem_arbiter
    import dnn_accel_system_cpu_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [JDO_W-1:0]  jdo,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t            state, state_nxt;
    logic              rd_jtag, rd_jtag_nxt;
    logic              last_jtag, last_jtag_nxt;
    logic              jp_clear, addr_inc, mon_load, capture, jp_valid, av_req;
    jtag_op_t          jp_op;
    logic [ADDR_W-1:0] jp_addr;
    logic [ADDR_W-1:0] jtag_addr;
    logic [DATA_W-1:0] jp_data;

    dnn_accel_system_cpu_ocimem_jtag_cmd #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_jtag_cmd (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .jp_clear                (jp_clear),
        .addr_inc                (addr_inc),
        .capture                 (capture),
        .jp_valid                (jp_valid),
        .jp_op                   (jp_op),
        .jp_addr                 (jp_addr),
        .jp_data                 (jp_data),
        .jtag_addr               (jtag_addr),
        .jtag_overrun            (jtag_overrun)
    );

    assign av_req      = av_read | av_write;
    assign av_readdata = ram_rdata;

    // Outputs are forced idle while reset is held so no partial access escapes.
    always_comb begin
        state_nxt      = state;
        rd_jtag_nxt    = rd_jtag;
        last_jtag_nxt  = last_jtag;
        ram_en         = 1'b0;
        ram_wren       = 1'b0;
        ram_addr       = av_address;
        ram_byteen     = av_byteenable;
        ram_wdata      = av_writedata;
        av_waitrequest = 1'b1;
        jp_clear       = 1'b0;
        addr_inc       = 1'b0;
        mon_load       = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (jp_valid && !(last_jtag && av_req)) begin
                        last_jtag_nxt = 1'b1;
                        jp_clear      = 1'b1;
                        ram_addr      = jp_addr;
                        ram_byteen    = 4'hF;
                        ram_wdata     = jp_data;
                        case (jp_op)
                            OP_WRITE: begin
                                ram_en   = 1'b1;
                                ram_wren = 1'b1;
                                addr_inc = 1'b1;
                            end
                            OP_LOAD_RD, OP_READ: begin
                                ram_en      = 1'b1;
                                rd_jtag_nxt = 1'b1;
                                state_nxt   = RD_WAIT;
                            end
                            default: ;
                        endcase
                    end else if (av_req) begin
                        last_jtag_nxt = 1'b0;
                        ram_en        = 1'b1;
                        if (av_write) begin
                            ram_wren       = 1'b1;
                            av_waitrequest = 1'b0;
                        end else begin
                            rd_jtag_nxt = 1'b0;
                            state_nxt   = RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    state_nxt = IDLE;
                    if (rd_jtag) begin
                        mon_load = 1'b1;
                        addr_inc = 1'b1;
                    end else begin
                        av_waitrequest = 1'b0;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rd_jtag       <= 1'b0;
            last_jtag     <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_jtag   <= rd_jtag_nxt;
            last_jtag <= last_jtag_nxt;
            if (mon_load) MonDReg <= ram_rdata;
            if (capture)
                monitor_ready <= 1'b0;
            else if (mon_load)
                monitor_ready <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dnn_accel_system_cpu_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a behavioural byte-enabled RAM.
module tb_dnn_accel_system_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [37:0] jdo;
    logic [31:0] MonDReg;
    logic        monitor_ready, jtag_overrun;
    logic [7:0]  av_address;
    logic        av_read, av_write;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_en, ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:255];
    int          vectors;
    int          miscompares;

    always #5 clk = ~clk;

    dnn_accel_system_cpu_ocimem_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .jdo                     (jdo),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_en                  (ram_en),
        .ram_wren                (ram_wren),
        .ram_byteen              (ram_byteen),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata)
    );

    // Synchronous single-port RAM, read data one cycle after the access.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wren) begin
                for (int k = 0; k < 4; k++)
                    if (ram_byteen[k]) mem[ram_addr][8*k +: 8] <= ram_wdata[8*k +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic [7:0] addr, input logic rd);
        logic [37:0] v;
        v        = '0;
        v[25:18] = addr;
        v[17]    = rd;
        return v;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] v;
        v       = '0;
        v[34:3] = data;
        return v;
    endfunction

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_a; one-cycle pulse
    task automatic jtag(input int kind, input logic [37:0] d);
        jdo                     = d;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        step();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic av_wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        av_address    = a;
        av_writedata  = d;
        av_byteenable = be;
        av_write      = 1'b1;
        #1;
        chk(tag, 64'(av_waitrequest), 64'd0);
        step();
        av_write = 1'b0;
    endtask

    initial begin
        int lows;
        int at;
        logic [31:0] rd;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        jdo = '0;
        av_address = '0;
        av_read = 1'b0;
        av_write = 1'b0;
        av_writedata = '0;
        av_byteenable = '0;
        idle(2);
        chk("rst_mondreg", 64'(MonDReg), 64'd0);
        chk("rst_monitor_ready", 64'(monitor_ready), 64'd0);
        chk("rst_overrun", 64'(jtag_overrun), 64'd0);
        chk("rst_waitrequest", 64'(av_waitrequest), 64'd1);
        chk("rst_ram_en", 64'(ram_en), 64'd0);
        reset = 1'b0;
        step();

        // JTAG address load then two writes with auto-increment
        jtag(0, mk_a(8'h10, 1'b0)); idle(3);
        jtag(1, mk_b(32'hDEADBEEF)); idle(3);
        jtag(1, mk_b(32'h12345678)); idle(3);
        chk("jwr_0x10", 64'(mem[8'h10]), 64'hDEADBEEF);
        chk("jwr_0x11", 64'(mem[8'h11]), 64'h12345678);
        jtag(1, mk_b(32'hCAFE0001)); idle(3);
        chk("jwr_0x12", 64'(mem[8'h12]), 64'hCAFE0001);

        // JTAG read latency: RAM access at t+1, MonDReg valid at t+3
        jtag(0, mk_a(8'h10, 1'b1));
        chk("jrd_ram_en", 64'(ram_en), 64'd1);
        chk("jrd_ram_wren", 64'(ram_wren), 64'd0);
        chk("jrd_ram_addr", 64'(ram_addr), 64'h10);
        step();
        chk("jrd_not_ready_t2", 64'(monitor_ready), 64'd0);
        step();
        chk("jrd_mondreg_0x10", 64'(MonDReg), 64'hDEADBEEF);
        chk("jrd_ready_t3", 64'(monitor_ready), 64'd1);
        jtag(2, '0);
        chk("noact_clears_ready", 64'(monitor_ready), 64'd0);
        idle(2);
        chk("noact_mondreg_0x11", 64'(MonDReg), 64'h12345678);
        jtag(2, '0); idle(2);
        chk("noact_mondreg_0x12", 64'(MonDReg), 64'hCAFE0001);

        // Address wrap 0xFF -> 0x00
        jtag(0, mk_a(8'hFF, 1'b0)); idle(3);
        jtag(1, mk_b(32'h11111111)); idle(3);
        jtag(1, mk_b(32'h22222222)); idle(3);
        chk("wrap_0xff", 64'(mem[8'hFF]), 64'h11111111);
        chk("wrap_0x00", 64'(mem[8'h00]), 64'h22222222);

        // Avalon writes (single cycle) including byte enables
        av_wr("avwr_full_wait", 8'h30, 32'hFFFFFFFF, 4'hF);
        av_wr("avwr_be_wait", 8'h30, 32'hAABBCCDD, 4'b0101);
        chk("avwr_be_data", 64'(mem[8'h30]), 64'hFFBBFFDD);
        av_wr("avwr_0x20_wait", 8'h20, 32'h5A5A0020, 4'hF);
        av_read = 1'b1;
        av_wr("avrdwr_as_write", 8'h31, 32'h00000031, 4'hF);
        av_read = 1'b0;
        chk("avrdwr_data", 64'(mem[8'h31]), 64'h00000031);

        // Uncontended Avalon read: two cycles
        av_address = 8'h30;
        av_read = 1'b1;
        #1;
        chk("avrd_c1_wait", 64'(av_waitrequest), 64'd1);
        step();
        chk("avrd_c2_wait", 64'(av_waitrequest), 64'd0);
        chk("avrd_c2_data", 64'(av_readdata), 64'hFFBBFFDD);
        av_read = 1'b0;
        step();

        // Contention: JTAG write pending when Avalon read arrives
        jtag(1, mk_b(32'h0BADF00D));
        av_address = 8'h20;
        av_read = 1'b1;
        #1;
        chk("contend_jtag_first", 64'(ram_wren), 64'd1);
        chk("contend_jtag_addr", 64'(ram_addr), 64'h01);
        lows = 0;
        at = 0;
        rd = '0;
        for (int c = 1; c <= 6; c++) begin
            if (!av_waitrequest) begin
                lows++;
                at = c;
                rd = av_readdata;
                av_read = 1'b0;
            end
            step();
        end
        chk("contend_wait_low_cycles", 64'(lows), 64'd1);
        chk("contend_done_cycle", 64'(at), 64'd3);
        chk("contend_readdata", 64'(rd), 64'h5A5A0020);
        chk("contend_jtag_data", 64'(mem[8'h01]), 64'h0BADF00D);

        // Reset while an Avalon read sits in RD_WAIT with a JTAG write pending
        jdo = mk_b(32'h77777777);
        take_action_ocimem_b = 1'b1;
        av_address = 8'h20;
        av_read = 1'b1;
        step();
        take_action_ocimem_b = 1'b0;
        reset = 1'b1;
        #1;
        chk("rdw_rst_waitrequest", 64'(av_waitrequest), 64'd1);
        chk("rdw_rst_mondreg", 64'(MonDReg), 64'd0);
        chk("rdw_rst_ready", 64'(monitor_ready), 64'd0);
        chk("rdw_rst_ram_en", 64'(ram_en), 64'd0);
        step();
        av_read = 1'b0;
        reset = 1'b0;
        step();
        chk("rdw_rst_jp_dropped", 64'(ram_en), 64'd0);
        idle(2);
        chk("rdw_rst_no_write", 64'(mem[8'h00]), 64'h22222222);

        // Back-to-back JTAG pulses set the sticky overrun flag
        jtag(1, mk_b(32'h33333333));
        chk("overrun_single", 64'(jtag_overrun), 64'd0);
        jtag(1, mk_b(32'h44444444));
        chk("overrun_set", 64'(jtag_overrun), 64'd1);
        idle(4);
        chk("overrun_sticky", 64'(jtag_overrun), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dnn_accel_system_cpu_ocimem_arbiter.md
Name: dnn_accel_system_cpu_ocimem_arbiter

Overview:
Arbitrates the CPU debug module's single-port on-chip debug RAM (OCI RAM) between two requesters. One is the JTAG debug path, which issues single-cycle take_action/take_no_action pulses plus the jdo payload in the sysclk domain. The other is the Avalon debug_slave port used by the CPU in debug mode. The block sequences RAM reads and writes, auto-increments the JTAG address, and captures read data into MonDReg for shift-out.

Parameters:
ADDR_W, 8, OCI RAM word-address width (256 words)
DATA_W, 32, RAM/Avalon data width (fixed 32; jdo slicing assumes it)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
take_action_ocimem_a  in  1  JTAG: load address jdo[25:18]; if jdo[17]=1 also read at that address
take_action_ocimem_b  in  1  JTAG: write jdo[34:3] at jtag_addr, then increment
take_no_action_ocimem_a  in  1  JTAG: read at jtag_addr, then increment
jdo  in  38  JTAG command payload, valid with the pulses
MonDReg  out  32  last JTAG read data
monitor_ready  out  1  JTAG read complete, MonDReg valid
jtag_overrun  out  1  sticky: JTAG pulse arrived while a JTAG op was pending
av_address  in  ADDR_W  Avalon word address
av_read  in  1  Avalon read
av_write  in  1  Avalon write
av_writedata  in  32  Avalon write data
av_byteenable  in  4  Avalon byte enables
av_readdata  out  32  Avalon read data
av_waitrequest  out  1  Avalon stall
ram_addr  out  ADDR_W  RAM address
ram_en  out  1  RAM access enable
ram_wren  out  1  RAM write enable
ram_byteen  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid 1 cycle after ram_en with ram_wren=0

Behaviour:
- Reset (async, immediate):
  - state=IDLE; jp_valid=0; jtag_addr=0.
  - MonDReg=0; monitor_ready=0; jtag_overrun=0.
  - av_waitrequest=1; ram_en=0; ram_wren=0; last_jtag=0.
  - Any in-flight op is aborted: no partial write, no readdata returned.
- JTAG capture:
  - Any pulse at edge t registers the op into the pending slot (jp_op, jp_addr, jp_data). jp_valid=1 from t+1.
  - ocimem_a updates jtag_addr immediately at capture.
  - Each capture clears monitor_ready.
  - A pulse while jp_valid=1 overwrites the slot and sets jtag_overrun (cleared only by reset).
  - Simultaneous pulses: priority ocimem_b > ocimem_a > no_action_a.
- FSM states: IDLE, RD_WAIT.
- In IDLE, grant selection:
  - Grant JTAG if jp_valid and not (last_jtag and an Avalon request is pending).
  - Otherwise grant Avalon if av_read or av_write.
  - Otherwise no grant.
  - After a JTAG grant, a waiting Avalon request wins the next grant, so neither side starves.
- Write grant (either side):
  - ram_en=ram_wren=1 for one cycle.
  - Avalon: av_waitrequest=0 in that same cycle; byteenable is passed through.
  - JTAG: ram_byteen=4'hF; jtag_addr increments mod 2^ADDR_W (0xFF wraps to 0x00); jp_valid clears.
  - Stay in IDLE.
- Read grant:
  - ram_en=1, ram_wren=0; go to RD_WAIT.
  - In RD_WAIT, Avalon read: av_readdata=ram_rdata and av_waitrequest=0 in that cycle.
  - In RD_WAIT, JTAG read: MonDReg<=ram_rdata and monitor_ready<=1 at the end of the cycle; no_action_a increments jtag_addr.
  - Return to IDLE; no issue in RD_WAIT, so back-to-back reads cost 2 cycles each.
- av_waitrequest=1 in all other cycles.
- Avalon read and write asserted together: treated as a write.
- Latency:
  - JTAG pulse at t: RAM write at t+1 if granted; MonDReg valid at t+3.
  - Avalon write: 1 cycle when uncontended.
  - Avalon read: 2 cycles when uncontended.

Decomposition:
- Package dnn_accel_system_cpu_ocimem_pkg holds:
  - enum jtag_op_t {OP_LOAD, OP_LOAD_RD, OP_WRITE, OP_READ} and state_t {IDLE, RD_WAIT}.
  - jdo field constants: JDO_ADDR_HI=25, JDO_ADDR_LO=18, JDO_RDEN=17, JDO_WD_HI=34, JDO_WD_LO=3.
- One sub-module: dnn_accel_system_cpu_ocimem_jtag_cmd, which decodes the pulses, holds the pending slot and jtag_addr, and flags overrun. The grant FSM stays in the top level.

Test Plan:
- ocimem_a with jdo[25:18]=0x10, jdo[17]=0; then ocimem_b ×2 with data 0xDEADBEEF, 0x12345678 → RAM[0x10]=0xDEADBEEF, RAM[0x11]=0x12345678, jtag_addr=0x12.
- ocimem_a with addr 0x10, jdo[17]=1 → MonDReg=0xDEADBEEF and monitor_ready=1 three cycles after the pulse; then no_action_a → MonDReg=0x12345678.
- ocimem_a addr 0xFF, then ocimem_b ×2 → writes land at 0xFF then 0x00 (wrap).
- Avalon read of 0x20 held continuously while a JTAG write pulse arrives → JTAG write granted first, Avalon read completes within the following 3 cycles; av_waitrequest low for exactly 1 cycle.
- Avalon write 0xAABBCCDD with byteenable 4'b0101 over 0xFFFFFFFF → RAM=0xFFBBFFDD; uncontended av_waitrequest=0 in the first cycle.
- Assert reset in RD_WAIT → av_waitrequest=1, monitor_ready=0, MonDReg=0, jp_valid=0 immediately; no readdata handshake completes. Two JTAG pulses 1 cycle apart → jtag_overrun=1.
